baser_257b_block_scheduler: RTL and testbench
=============================================

Name: baser_257b_block_scheduler

Overview:
- Arbitrates three 64b block sources (data, control, ordered-set) into the four slots of a 257b transcoded block.
- Assembles each block per 256b/257b transcoding rules and presents it with a valid/ready handshake.
- Sits in front of the 257b receive checker as the stimulus/traffic scheduler of the transcoded-block path.

Parameters:
DATA_WIDTH, 64, width of one 64b block
TC_DATA_WIDTH, 4*DATA_WIDTH, payload width of the transcoded block
TC_WIDTH, TC_DATA_WIDTH+1, full transcoded block width (257)
DATA_CHAR_PATTERN, 8'hAA, data byte pattern
CTRL_CHAR_PATTERN, 7'h1E, 7-bit control character pattern
OSET_CHAR_PATTERN, 4'hF, ordered-set O-code
IDLE_TIMEOUT, 16, idle cycles before pad-fill (optional feature only)

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  3  requests: [0] data, [1] control, [2] ordered-set
o_gnt  out  3  one-hot grant, combinational from i_req and state
i_en  in  1  scheduler enable; 0 blocks new grants
o_tx_coded  out  TC_WIDTH  assembled transcoded block
o_valid  out  1  o_tx_coded valid
i_ready  in  1  downstream accepts
o_block_count  out  32  257b blocks accepted downstream
o_ctrl_count  out  32  accepted blocks with header 0

Behaviour:
- Reset: all outputs 0; slot index 0; round-robin pointer favours data; state FILL.
- States:
  - FILL: o_gnt nonzero only if i_en=1 and i_req!=0. One grant per cycle, round-robin; priority starts after the last granted source. At the clock edge the granted 64b block is stored in the current slot and the slot index increments. Grant on slot 3 moves to HOLD.
  - HOLD: o_valid=1 starting the cycle after the 4th grant; o_gnt=0. o_tx_coded stays stable until a cycle with i_ready=1. On acceptance: counters update, slot index returns to 0, next state is FILL. One bubble cycle per block (no grant in the accepting cycle).
- Slot contents (64 bits, LSB first):
  - Data: 8x DATA_CHAR_PATTERN.
  - Control: type 8'h1E, then 8x CTRL_CHAR_PATTERN.
  - Ordered set: type 8'h4B, 3x DATA_CHAR_PATTERN, OSET_CHAR_PATTERN, 28 zero bits.
- Assembly:
  - All four slots data: bit0=1, bits[256:1] = slot0..slot3 concatenated LSB-first.
  - Otherwise: bit0=0; bits[4:1] = mask, mask[k]=1 iff slot k is data. Blocks are then packed LSB-first from bit 5 in slot order. The first control slot drops its type's low nibble (type[7:4] only, then its 56 remaining bits). Later control slots keep the full 64 bits. Total width is always 257.
- Counters wrap modulo 2^32. o_ctrl_count increments with o_block_count when accepted bit0=0.
- i_en=0 mid-fill: partial slots are retained; filling resumes on re-enable. i_en has no effect in HOLD.
- Reset mid-operation: partial block and HOLD block are discarded; no count.

Optional Feature:
- Macro: BASER_SCHED_IDLE_FILL_EN.
- With it: in FILL with slot index >0, a counter runs over consecutive cycles with no grant. At IDLE_TIMEOUT it fills the remaining slots with control blocks in one cycle and enters HOLD. The counter clears on any grant or on leaving FILL.
- Without it: a partial block waits indefinitely.

Decomposition:
- Package baser_257b_pkg holds: slot-kind enum (DATA, CTRL, OSET), block-type constants 8'h1E/8'h4B, and state enum.
- One natural sub-module: baser_257b_rr_arbiter (3-way round-robin, combinational grant, registered pointer).

Test Plan:
- data only, i_ready=1: 4 grants → o_tx_coded = {32{8'hAA}},1'b1; o_block_count=1, o_ctrl_count=0.
- Grant order ctrl, data, data, data:
  - bit0=0; bits[4:1]=4'b1110; bits[8:5]=4'h1; bits[64:9]={8{7'h1E}}; bits[256:65]={24{8'hAA}}.
  - o_ctrl_count=1.
- i_req=3'b111 held: grants data, ctrl, oset, data → mask 4'b1001; slot2 appears as full 64b 8'h4B block; next block starts with ctrl grant.
- HOLD with i_ready=0 for 10 cycles: o_tx_coded unchanged, o_gnt=0, counters unchanged; then i_ready=1 → counts +1.
- 2 grants, then i_rst_n=0 for 1 cycle: outputs 0; next 4 data grants produce an all-data block.
- With BASER_SCHED_IDLE_FILL_EN, IDLE_TIMEOUT=16:
  - 1 data grant, then no requests → o_valid rises 17 cycles later.
  - mask 4'b0001; bits[8:5]=4'h1; the ctrl slot after it keeps full type 8'h1E.

Source files
------------

// File: rtl/baser_257b_block_scheduler_pkg.sv
// Shared types and constants for the 257b transcoded-block scheduler.
// The optional idle pad-fill is built only when BASER_SCHED_IDLE_FILL_EN is defined.
package baser_257b_pkg;

  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned TC_DATA_WIDTH = 4 * DATA_WIDTH;
  localparam int unsigned TC_WIDTH      = TC_DATA_WIDTH + 1;
  localparam int unsigned NUM_SLOTS     = 4;

  localparam logic [7:0] DATA_CHAR_PATTERN = 8'hAA;
  localparam logic [6:0] CTRL_CHAR_PATTERN = 7'h1E;
  localparam logic [3:0] OSET_CHAR_PATTERN = 4'hF;

  localparam logic [7:0] CTRL_BLOCK_TYPE = 8'h1E;
  localparam logic [7:0] OSET_BLOCK_TYPE = 8'h4B;

  // Encoding matches the request/grant bit index of each source.
  typedef enum logic [1:0] {
    KindData = 2'd0,
    KindCtrl = 2'd1,
    KindOset = 2'd2
  } slot_kind_e;

  typedef enum logic [0:0] {
    StFill = 1'b0,
    StHold = 1'b1
  } sched_state_e;

  // 64b block content for a slot kind, LSB first.
  function automatic logic [DATA_WIDTH-1:0] slot_block(input slot_kind_e kind);
    logic [DATA_WIDTH-1:0] blk;
    case (kind)
      KindCtrl: blk = {{8{CTRL_CHAR_PATTERN}}, CTRL_BLOCK_TYPE};
      KindOset: blk = {28'h0, OSET_CHAR_PATTERN, {3{DATA_CHAR_PATTERN}}, OSET_BLOCK_TYPE};
      default:  blk = {8{DATA_CHAR_PATTERN}};
    endcase
    return blk;
  endfunction

endpackage

// File: rtl/baser_257b_block_scheduler_if.sv
// Source request/grant and transcoded-block output bundle of the scheduler.
// The scheduler takes the master side; the traffic sources and sink take the slave side.
interface baser_257b_block_scheduler_if;
  import baser_257b_pkg::*;

  logic [2:0]          i_req;
  logic [2:0]          o_gnt;
  logic                i_en;
  logic [TC_WIDTH-1:0] o_tx_coded;
  logic                o_valid;
  logic                i_ready;
  logic [31:0]         o_block_count;
  logic [31:0]         o_ctrl_count;

  modport master (
    input  i_req, i_en, i_ready,
    output o_gnt, o_tx_coded, o_valid, o_block_count, o_ctrl_count
  );

  modport slave (
    output i_req, i_en, i_ready,
    input  o_gnt, o_tx_coded, o_valid, o_block_count, o_ctrl_count
  );

endinterface

// File: rtl/baser_257b_rr_arbiter.sv
// 3-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
// After a grant, priority starts at the source following the one just granted.
module baser_257b_rr_arbiter (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic       i_en,
  output logic [2:0] o_gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic [2:0] idx;

  // Scan requesters starting at the pointer, wrapping modulo 3; first hit wins.
  always_comb begin
    o_gnt = '0;
    idx   = '0;
    if (i_en) begin
      for (int off = 0; off < 3; off++) begin
        idx = {1'b0, ptr_q} + 3'(off);
        if (idx >= 3'd3) idx = idx - 3'd3;
        if ((o_gnt == 3'b000) && i_req[idx[1:0]]) o_gnt[idx[1:0]] = 1'b1;
      end
    end
  end

  // Move the pointer just past whichever source was granted.
  always_comb begin
    ptr_d = ptr_q;
    if (o_gnt[0])      ptr_d = 2'd1;
    else if (o_gnt[1]) ptr_d = 2'd2;
    else if (o_gnt[2]) ptr_d = 2'd0;
  end

  // Pointer register; reset favours the data source.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 2'd0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/baser_257b_block_scheduler.sv
// Schedules data/control/ordered-set 64b blocks into the four slots of a 257b
// transcoded block and offers the assembled block over valid/ready.
// Optional feature macro: BASER_SCHED_IDLE_FILL_EN (pad a stalled partial block
// with control blocks after IDLE_TIMEOUT idle cycles).
module baser_257b_block_scheduler
  import baser_257b_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input logic                          clk,
  input logic                          i_rst_n,
  baser_257b_block_scheduler_if.master bus
);

  typedef logic [$clog2(IDLE_TIMEOUT + 1)-1:0] idle_cnt_t;

  sched_state_e                state_q, state_d;
  logic [1:0]                  slot_q, slot_d;
  logic [NUM_SLOTS-1:0][1:0]   kind_q, kind_d;
  logic [31:0]                 block_cnt_q, block_cnt_d;
  logic [31:0]                 ctrl_cnt_q, ctrl_cnt_d;
  logic [2:0]                  gnt;
  logic                        gnt_en;
  slot_kind_e                  gnt_kind;
  logic                        valid;
  logic [TC_WIDTH-1:0]         coded;
  logic [NUM_SLOTS-1:0]        data_mask;
  logic [8:0]                  pos;
  logic                        first_nd;
  logic [DATA_WIDTH-1:0]       blk;
`ifdef BASER_SCHED_IDLE_FILL_EN
  idle_cnt_t                   idle_q, idle_d;
`endif

  assign gnt_en = (state_q == StFill) && bus.i_en;

  baser_257b_rr_arbiter u_arb (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_req   (bus.i_req),
    .i_en    (gnt_en),
    .o_gnt   (gnt)
  );

  // Map the one-hot grant to the kind of block stored in the slot.
  always_comb begin
    gnt_kind = KindData;
    if (gnt[1])      gnt_kind = KindCtrl;
    else if (gnt[2]) gnt_kind = KindOset;
  end

  // Slot filling, HOLD handshake and accepted-block counters.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    kind_d      = kind_q;
    block_cnt_d = block_cnt_q;
    ctrl_cnt_d  = ctrl_cnt_q;
`ifdef BASER_SCHED_IDLE_FILL_EN
    idle_d      = idle_q;
`endif
    unique case (state_q)
      StFill: begin
        if (gnt != 3'b000) begin
          kind_d[slot_q] = gnt_kind;
          slot_d         = slot_q + 2'd1;
          if (slot_q == 2'd3) state_d = StHold;
`ifdef BASER_SCHED_IDLE_FILL_EN
          idle_d = '0;
`endif
        end
`ifdef BASER_SCHED_IDLE_FILL_EN
        else if (slot_q != 2'd0) begin
          if (idle_q == idle_cnt_t'(IDLE_TIMEOUT - 1)) begin
            // Pad every still-empty slot with a control block in one go.
            for (int k = 0; k < NUM_SLOTS; k++) begin
              if (2'(k) >= slot_q) kind_d[k] = KindCtrl;
            end
            state_d = StHold;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + idle_cnt_t'(1);
          end
        end else begin
          idle_d = '0;
        end
`endif
      end
      StHold: begin
`ifdef BASER_SCHED_IDLE_FILL_EN
        idle_d = '0;
`endif
        if (bus.i_ready) begin
          state_d     = StFill;
          slot_d      = 2'd0;
          block_cnt_d = block_cnt_q + 32'd1;
          if (!coded[0]) ctrl_cnt_d = ctrl_cnt_q + 32'd1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // 257b assembly from the stored slot kinds. Any non-data slot (control or
  // ordered set) counts as a control block; the first one sheds its type's low
  // nibble so that the mask plus payload always totals 257 bits.
  always_comb begin
    coded    = '0;
    pos      = 9'd5;
    first_nd = 1'b1;
    blk      = '0;
    for (int k = 0; k < NUM_SLOTS; k++) data_mask[k] = (kind_q[k] == KindData);
    if (&data_mask) begin
      coded[0] = 1'b1;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        coded[k*DATA_WIDTH+1 +: DATA_WIDTH] = slot_block(slot_kind_e'(kind_q[k]));
      end
    end else begin
      coded[NUM_SLOTS:1] = data_mask;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        blk = slot_block(slot_kind_e'(kind_q[k]));
        if (!data_mask[k] && first_nd) begin
          coded    = coded | (TC_WIDTH'(blk[DATA_WIDTH-1:4]) << pos);
          pos      = pos + 9'd60;
          first_nd = 1'b0;
        end else begin
          coded = coded | (TC_WIDTH'(blk) << pos);
          pos   = pos + 9'd64;
        end
      end
    end
  end

  assign valid             = (state_q == StHold);
  assign bus.o_valid       = valid;
  assign bus.o_tx_coded    = valid ? coded : '0;
  assign bus.o_gnt         = gnt;
  assign bus.o_block_count = block_cnt_q;
  assign bus.o_ctrl_count  = ctrl_cnt_q;

  // State registers; reset discards any partial or held block.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StFill;
      slot_q      <= 2'd0;
      kind_q      <= '0;
      block_cnt_q <= '0;
      ctrl_cnt_q  <= '0;
`ifdef BASER_SCHED_IDLE_FILL_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      kind_q      <= kind_d;
      block_cnt_q <= block_cnt_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
`ifdef BASER_SCHED_IDLE_FILL_EN
      idle_q      <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_baser_257b_block_scheduler.sv
// Self-checking bench for baser_257b_block_scheduler: a reference model predicts
// grants and pushes expected 257b blocks to a queue that is popped on acceptance.
module tb_baser_257b_block_scheduler;
  import baser_257b_pkg::*;

  localparam int unsigned IDLE_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  baser_257b_block_scheduler_if bus ();

  baser_257b_block_scheduler #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic         m_hold;
  int           m_slot, m_ptr, m_idle;
  int           m_kind[4];
  logic [31:0]  m_blocks, m_ctrls;
  logic [256:0] m_cur;
  logic [256:0] exp_q[$];

  // Per-cycle observations and predictions
  logic [2:0]   obs_gnt, exp_gnt;
  logic         obs_valid, exp_valid, acc;
  logic [256:0] obs_coded;
  logic [31:0]  obs_bc, obs_cc, exp_bc, exp_cc;

  function automatic logic [63:0] tb_slot(input int kind);
    logic [63:0] b;
    b = '0;
    if (kind == 1) begin
      b[7:0] = 8'h1E;
      for (int i = 0; i < 8; i++) b[8+7*i +: 7] = 7'h1E;
    end else if (kind == 2) begin
      b[7:0]   = 8'h4B;
      b[31:8]  = 24'hAAAAAA;
      b[35:32] = 4'hF;
    end else begin
      for (int i = 0; i < 8; i++) b[8*i +: 8] = 8'hAA;
    end
    return b;
  endfunction

  // Builds the expected block as a bit stream, appending fields in order.
  function automatic logic [256:0] tb_assemble(input int kinds[4]);
    logic         q[$];
    logic [256:0] r;
    logic [63:0]  b;
    logic         all_d, first;
    int           lo;
    all_d = 1'b1;
    for (int i = 0; i < 4; i++) if (kinds[i] != 0) all_d = 1'b0;
    q.push_back(all_d);
    if (!all_d) for (int i = 0; i < 4; i++) q.push_back(kinds[i] == 0);
    first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b  = tb_slot(kinds[i]);
      lo = 0;
      if (!all_d && kinds[i] != 0 && first) begin
        lo    = 4;
        first = 1'b0;
      end
      for (int j = lo; j < 64; j++) q.push_back(b[j]);
    end
    r = '0;
    for (int i = 0; i < 257 && i < q.size(); i++) r[i] = q[i];
    return r;
  endfunction

  function automatic logic [2:0] rr_pick(input logic [2:0] req, input int ptr);
    logic [2:0] g;
    g = '0;
    for (int o = 0; o < 3; o++) begin
      int i;
      i = (ptr + o) % 3;
      if (g == 3'b000 && req[i]) g[i] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_clear();
    m_hold = 1'b0; m_slot = 0; m_ptr = 0; m_idle = 0;
    m_blocks = '0; m_ctrls = '0; m_cur = '0;
    for (int i = 0; i < 4; i++) m_kind[i] = 0;
    exp_q.delete();
  endtask

  // Hold reset low for one cycle with idle inputs, sampling outputs mid-reset.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = 3'b000; bus.i_en = 1'b0; bus.i_ready = 1'b0;
    @(negedge clk);
    obs_gnt = bus.o_gnt; obs_valid = bus.o_valid; obs_coded = bus.o_tx_coded;
    obs_bc = bus.o_block_count; obs_cc = bus.o_ctrl_count;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive, sample at negedge, predict, then advance the model.
  task automatic tick(input logic [2:0] req, input logic en, input logic rdy);
    int k;
    bus.i_req = req; bus.i_en = en; bus.i_ready = rdy;
    @(negedge clk);
    obs_gnt = bus.o_gnt; obs_valid = bus.o_valid; obs_coded = bus.o_tx_coded;
    obs_bc = bus.o_block_count; obs_cc = bus.o_ctrl_count;
    exp_gnt   = (!m_hold && en) ? rr_pick(req, m_ptr) : 3'b000;
    exp_valid = m_hold;
    exp_bc    = m_blocks;
    exp_cc    = m_ctrls;
    acc       = m_hold && rdy;
    @(posedge clk); #1;
    if (m_hold) begin
      if (rdy) begin
        m_hold = 1'b0; m_slot = 0;
        m_blocks = m_blocks + 32'd1;
        if (!m_cur[0]) m_ctrls = m_ctrls + 32'd1;
      end
    end else if (exp_gnt != 3'b000) begin
      k = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
      m_kind[m_slot] = k;
      m_ptr  = (k + 1) % 3;
      m_idle = 0;
      if (m_slot == 3) begin
        m_hold = 1'b1;
        m_cur  = tb_assemble(m_kind);
        exp_q.push_back(m_cur);
      end else begin
        m_slot++;
      end
    end
`ifdef BASER_SCHED_IDLE_FILL_EN
    else if (m_slot > 0) begin
      if (m_idle == IDLE_TIMEOUT - 1) begin
        for (int i = m_slot; i < 4; i++) m_kind[i] = 1;
        m_hold = 1'b1; m_idle = 0;
        m_cur  = tb_assemble(m_kind);
        exp_q.push_back(m_cur);
      end else begin
        m_idle++;
      end
    end else begin
      m_idle = 0;
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({obs_gnt, obs_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset gnt/valid: got %b/%b want 000/0", obs_gnt, obs_valid);
    end
    n_total++;
    if (obs_coded !== 257'd0) begin
      n_bad++; $display("FAIL reset tx_coded: got %h want 0", obs_coded);
    end
    n_total++;
    if ({obs_bc, obs_cc} !== 64'd0) begin
      n_bad++; $display("FAIL reset counts: got %0d/%0d want 0/0", obs_bc, obs_cc);
    end
    tick(3'b111, 1'b0, 1'b0);
    n_total++;
    if ({obs_gnt, obs_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset disabled gnt/valid: got %b/%b want 000/0", obs_gnt, obs_valid);
    end
  endtask

  task automatic test_data_only();
    logic [256:0] e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick(3'b001, 1'b1, 1'b1);
      n_total++;
      if ({obs_gnt, obs_valid} !== {exp_gnt, exp_valid}) begin
        n_bad++; $display("FAIL data_only gnt/valid c=%0d: got %b/%b want %b/%b",
                          c, obs_gnt, obs_valid, exp_gnt, exp_valid);
      end
      n_total++;
      if ({obs_bc, obs_cc} !== {exp_bc, exp_cc}) begin
        n_bad++; $display("FAIL data_only counts c=%0d: got %0d/%0d want %0d/%0d",
                          c, obs_bc, obs_cc, exp_bc, exp_cc);
      end
      if (acc) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL data_only block: accepted %h with none expected", obs_coded);
        end else begin
          e = exp_q.pop_front();
          if (obs_coded !== e) begin
            n_bad++; $display("FAIL data_only block: got %h want %h", obs_coded, e);
          end
        end
        n_total++;
        if (obs_coded !== {{32{8'hAA}}, 1'b1}) begin
          n_bad++; $display("FAIL data_only literal: got %h", obs_coded);
        end
      end
    end
    n_total++;
    if ({obs_bc, obs_cc} !== {32'd1, 32'd0}) begin
      n_bad++; $display("FAIL data_only final counts: got %0d/%0d want 1/0", obs_bc, obs_cc);
    end
  endtask

  task automatic test_ctrl_first();
    logic [2:0]   reqs[6];
    logic [256:0] e;
    reqs = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick(reqs[c], 1'b1, 1'b1);
      n_total++;
      if ({obs_gnt, obs_valid} !== {exp_gnt, exp_valid}) begin
        n_bad++; $display("FAIL ctrl_first gnt/valid c=%0d: got %b/%b want %b/%b",
                          c, obs_gnt, obs_valid, exp_gnt, exp_valid);
      end
      if (acc) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL ctrl_first block: accepted %h with none expected", obs_coded);
        end else begin
          e = exp_q.pop_front();
          if (obs_coded !== e) begin
            n_bad++; $display("FAIL ctrl_first block: got %h want %h", obs_coded, e);
          end
        end
        n_total++;
        if (obs_coded !== {{24{8'hAA}}, {8{7'h1E}}, 4'h1, 4'b1110, 1'b0}) begin
          n_bad++; $display("FAIL ctrl_first layout: got %h", obs_coded);
        end
      end
    end
    n_total++;
    if ({obs_bc, obs_cc} !== {32'd1, 32'd1}) begin
      n_bad++; $display("FAIL ctrl_first counts: got %0d/%0d want 1/1", obs_bc, obs_cc);
    end
  endtask

  task automatic test_all_req();
    logic [256:0] e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick(3'b111, 1'b1, 1'b1);
      n_total++;
      if ({obs_gnt, obs_valid} !== {exp_gnt, exp_valid}) begin
        n_bad++; $display("FAIL all_req gnt/valid c=%0d: got %b/%b want %b/%b",
                          c, obs_gnt, obs_valid, exp_gnt, exp_valid);
      end
      if (acc) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL all_req block: accepted %h with none expected", obs_coded);
        end else begin
          e = exp_q.pop_front();
          if (obs_coded !== e) begin
            n_bad++; $display("FAIL all_req block: got %h want %h", obs_coded, e);
          end
        end
        n_total++;
        if ({obs_coded[192:129], obs_coded[4:0]} !==
            {28'h0, 4'hF, 24'hAAAAAA, 8'h4B, 4'b1001, 1'b0}) begin
          n_bad++; $display("FAIL all_req mask/oset: got %h", obs_coded);
        end
      end
    end
    n_total++;
    if (obs_gnt !== 3'b010) begin
      n_bad++; $display("FAIL all_req next grant: got %b want 010", obs_gnt);
    end
  endtask

  task automatic test_hold_stall();
    logic [256:0] held, e;
    do_reset();
    for (int c = 0; c < 4; c++) tick(3'b001, 1'b1, 1'b0);
    tick(3'b001, 1'b1, 1'b0);
    held = obs_coded;
    for (int c = 0; c < 10; c++) begin
      tick(3'b001, 1'b1, 1'b0);
      n_total++;
      if ({obs_gnt, obs_valid, obs_coded} !== {3'b000, 1'b1, held}) begin
        n_bad++; $display("FAIL hold_stall c=%0d: got gnt=%b valid=%b coded=%h want 000/1/%h",
                          c, obs_gnt, obs_valid, obs_coded, held);
      end
      n_total++;
      if ({obs_bc, obs_cc} !== 64'd0) begin
        n_bad++; $display("FAIL hold_stall counts c=%0d: got %0d/%0d want 0/0", c, obs_bc, obs_cc);
      end
    end
    tick(3'b000, 1'b1, 1'b1);
    n_total++;
    if (!acc || exp_q.size() == 0) begin
      n_bad++; $display("FAIL hold_stall accept: got valid=%b want accepted block", obs_valid);
    end else begin
      e = exp_q.pop_front();
      if (obs_coded !== e) begin
        n_bad++; $display("FAIL hold_stall block: got %h want %h", obs_coded, e);
      end
    end
    tick(3'b000, 1'b1, 1'b1);
    n_total++;
    if ({obs_bc, obs_cc, obs_valid} !== {32'd1, 32'd0, 1'b0}) begin
      n_bad++; $display("FAIL hold_stall after: got %0d/%0d valid=%b want 1/0/0",
                        obs_bc, obs_cc, obs_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [256:0] e;
    do_reset();
    tick(3'b001, 1'b1, 1'b1);
    tick(3'b010, 1'b1, 1'b1);
    do_reset();
    n_total++;
    if ({obs_gnt, obs_valid, obs_coded, obs_bc, obs_cc} !== '0) begin
      n_bad++; $display("FAIL reset_mid partial: got gnt=%b valid=%b coded=%h counts=%0d/%0d",
                        obs_gnt, obs_valid, obs_coded, obs_bc, obs_cc);
    end
    for (int c = 0; c < 5; c++) tick(3'b010, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid hold: got valid=%b want 1", obs_valid);
    end
    do_reset();
    n_total++;
    if ({obs_valid, obs_coded, obs_bc} !== '0) begin
      n_bad++; $display("FAIL reset_mid held: got valid=%b coded=%h count=%0d",
                        obs_valid, obs_coded, obs_bc);
    end
    for (int c = 0; c < 6; c++) begin
      tick(3'b001, 1'b1, 1'b1);
      n_total++;
      if ({obs_gnt, obs_valid} !== {exp_gnt, exp_valid}) begin
        n_bad++; $display("FAIL reset_mid gnt/valid c=%0d: got %b/%b want %b/%b",
                          c, obs_gnt, obs_valid, exp_gnt, exp_valid);
      end
      if (acc) begin
        n_total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (obs_coded !== {{32{8'hAA}}, 1'b1} || e !== {{32{8'hAA}}, 1'b1}) begin
          n_bad++; $display("FAIL reset_mid block: got %h want all-data", obs_coded);
        end
      end
    end
    n_total++;
    if ({obs_bc, obs_cc} !== {32'd1, 32'd0}) begin
      n_bad++; $display("FAIL reset_mid counts: got %0d/%0d want 1/0", obs_bc, obs_cc);
    end
  endtask

  task automatic test_en_pause();
    logic [2:0]   reqs[10];
    logic         ens[10];
    logic [256:0] e;
    reqs = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b010, 3'b001, 3'b000};
    ens  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(reqs[c], ens[c], 1'b1);
      n_total++;
      if ({obs_gnt, obs_valid} !== {exp_gnt, exp_valid}) begin
        n_bad++; $display("FAIL en_pause gnt/valid c=%0d: got %b/%b want %b/%b",
                          c, obs_gnt, obs_valid, exp_gnt, exp_valid);
      end
      if (acc) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL en_pause block: accepted %h with none expected", obs_coded);
        end else begin
          e = exp_q.pop_front();
          if (obs_coded !== e || obs_coded[4:0] !== 5'b10110) begin
            n_bad++; $display("FAIL en_pause block: got %h want %h", obs_coded, e);
          end
        end
      end
    end
  endtask

  task automatic test_idle();
    logic [256:0] e;
    int           seen_at;
    do_reset();
    tick(3'b001, 1'b1, 1'b1);
    seen_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(3'b000, 1'b1, 1'b1);
      n_total++;
      if ({obs_gnt, obs_valid} !== {exp_gnt, exp_valid}) begin
        n_bad++; $display("FAIL idle gnt/valid i=%0d: got %b/%b want %b/%b",
                          i, obs_gnt, obs_valid, exp_gnt, exp_valid);
      end
      if (obs_valid === 1'b1 && seen_at == 0) seen_at = i;
      if (acc) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL idle block: accepted %h with none expected", obs_coded);
        end else begin
          e = exp_q.pop_front();
          if (obs_coded !== e) begin
            n_bad++; $display("FAIL idle block: got %h want %h", obs_coded, e);
          end
        end
        n_total++;
        if ({obs_coded[136:129], obs_coded[72:69], obs_coded[4:0]} !==
            {8'h1E, 4'h1, 4'b0001, 1'b0}) begin
          n_bad++; $display("FAIL idle layout: got %h", obs_coded);
        end
      end
    end
`ifdef BASER_SCHED_IDLE_FILL_EN
    n_total++;
    if (seen_at != IDLE_TIMEOUT + 1) begin
      n_bad++; $display("FAIL idle timeout: valid rose after %0d cycles want %0d",
                        seen_at, IDLE_TIMEOUT + 1);
    end
`else
    n_total++;
    if (seen_at != 0) begin
      n_bad++; $display("FAIL idle wait: valid rose after %0d cycles want never", seen_at);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.i_req = 3'b000; bus.i_en = 1'b0; bus.i_ready = 1'b0;
    model_clear();
    test_reset();
    test_data_only();
    test_ctrl_first();
    test_all_req();
    test_hold_stall();
    test_reset_mid();
    test_en_pause();
    test_idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
